// File: rtl/fp_mul_dispatch.sv
// Dispatches one operand pair to a set of multiplier engines, collects their results,
// optionally cross-checks them and drains them one at a time to a single consumer.
module fp_mul_dispatch #(
    parameter int SIZE     = 32,
    parameter int CHANNELS = 2,
    parameter int TIMEOUT  = 64,
    parameter int COMPARE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SIZE-1:0]          op1,
    input  logic [SIZE-1:0]          op2,
    input  logic [CHANNELS-1:0]      in_rdy,
    output logic [SIZE-1:0]          ch_op1,
    output logic [SIZE-1:0]          ch_op2,
    output logic [CHANNELS-1:0]      ch_start,
    input  logic [CHANNELS-1:0]      ch_done,
    input  logic [CHANNELS*SIZE-1:0] ch_res,
    output logic [SIZE-1:0]          res,
    output logic [CHANNELS-1:0]      res_rdy,
    input  logic                     res_ack,
    output logic                     busy,
    output logic                     mismatch,
    output logic                     timeout,
    output logic [1:0]               dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int          IW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]          state;
    logic [CHANNELS-1:0] mask;
    logic [CHANNELS-1:0] done;
    logic [CHANNELS-1:0] sent;
    logic [15:0]         timer;
    logic [SIZE-1:0]     hold      [CHANNELS];

    logic [CHANNELS-1:0] done_next;
    logic [SIZE-1:0]     hold_next [CHANNELS];
    logic                cmp_diff;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] grant;
    logic [IW-1:0]       sel_idx;

    // Only the first completion pulse of a selected engine is captured.
    always_comb begin
        done_next = done;
        hold_next = hold;
        if (state == S_WAIT) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_done[i] && mask[i] && !done[i]) begin
                    done_next[i] = 1'b1;
                    hold_next[i] = ch_res[i*SIZE +: SIZE];
                end
            end
        end
    end

    always_comb begin
        cmp_diff = 1'b0;
        if (COMPARE != 0) begin
            for (int i = 0; i < CHANNELS; i++) begin
                for (int j = i + 1; j < CHANNELS; j++) begin
                    if (done_next[i] && done_next[j] && (hold_next[i] != hold_next[j]))
                        cmp_diff = 1'b1;
                end
            end
        end
    end

    // Lowest-index completed channel not yet delivered.
    always_comb begin
        pending = done & ~sent;
        grant   = '0;
        sel_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                sel_idx  = IW'(i);
            end
        end
    end

    // Result handshake: res/res_rdy hold steady until a cycle with res_ack = 1 while
    // res_rdy != 0; that cycle transfers the result and the next one (if any) follows.
    always_comb begin
        res_rdy = '0;
        res     = '0;
        if (state == S_DRAIN && pending != '0) begin
            res_rdy = grant;
            res     = hold[sel_idx];
        end
    end

    assign ch_start  = (state == S_ISSUE) ? mask : '0;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mask     <= '0;
            done     <= '0;
            sent     <= '0;
            timer    <= '0;
            ch_op1   <= '0;
            ch_op2   <= '0;
            mismatch <= 1'b0;
            timeout  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) hold[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_rdy != '0) begin
                        ch_op1   <= op1;
                        ch_op2   <= op2;
                        mask     <= in_rdy;
                        done     <= '0;
                        sent     <= '0;
                        mismatch <= 1'b0;
                        timeout  <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    done <= done_next;
                    hold <= hold_next;
                    if (done_next == mask) begin
                        mismatch <= cmp_diff;
                        state    <= S_DRAIN;
                    end else if (timer == TMO_LAST) begin
                        // Give up on the stragglers; deliver whatever has completed.
                        timeout  <= 1'b1;
                        mismatch <= cmp_diff;
                        state    <= S_DRAIN;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (pending == '0)
                        state <= S_IDLE;
                    else if (res_ack)
                        sent <= sent | grant;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_dispatch.sv
// Directed bench for fp_mul_dispatch: one task per scenario with hand-computed expectations.
module tb_fp_mul_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op1, op2;
    logic [1:0]  in_rdy;
    logic [31:0] ch_op1, ch_op2;
    logic [1:0]  ch_start;
    logic [1:0]  ch_done;
    logic [63:0] ch_res;
    logic [31:0] res;
    logic [1:0]  res_rdy;
    logic        res_ack;
    logic        busy, mismatch, timeout;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    fp_mul_dispatch #(.SIZE(32), .CHANNELS(2), .TIMEOUT(64), .COMPARE(1)) dut (
        .clk(clk), .rst(rst), .op1(op1), .op2(op2), .in_rdy(in_rdy),
        .ch_op1(ch_op1), .ch_op2(ch_op2), .ch_start(ch_start),
        .ch_done(ch_done), .ch_res(ch_res), .res(res), .res_rdy(res_rdy),
        .res_ack(res_ack), .busy(busy), .mismatch(mismatch), .timeout(timeout),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_rdy = 2'b11; op1 = 32'h1111_1111; op2 = 32'h2222_2222;
        step();
        step();
        checks++;
        if ({ch_op1, ch_op2, ch_start, res, res_rdy, busy, mismatch, timeout} !== 103'd0) begin
            failures++;
            $display("FAIL reset_outputs: got op1=%h op2=%h start=%b res=%h rdy=%b busy=%b mis=%b tmo=%b required all zero",
                     ch_op1, ch_op2, ch_start, res, res_rdy, busy, mismatch, timeout);
        end
        rst = 1'b0; in_rdy = 2'b00;
        step();
        checks++;
        if (busy !== 1'b0 || ch_start !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b start=%b required 0/00", busy, ch_start);
        end
    endtask

    // Two-channel transaction; ch1 result given as r1 with a stray repeat pulse on ch0.
    task automatic test_dual(input string name, input logic [31:0] r1, input logic exp_mis);
        op1 = 32'h4000_0000; op2 = 32'h4000_0000; in_rdy = 2'b11;
        step();                                   // cycle 1: ISSUE
        in_rdy = 2'b00; op1 = 32'hDEAD_0001; op2 = 32'hDEAD_0002;
        checks++;
        if (ch_start !== 2'b11 || busy !== 1'b1 || ch_op1 !== 32'h4000_0000 || ch_op2 !== 32'h4000_0000) begin
            failures++;
            $display("FAIL %s_issue: got start=%b busy=%b op1=%h op2=%h required 11/1/40000000/40000000",
                     name, ch_start, busy, ch_op1, ch_op2);
        end
        step();                                   // cycle 2: WAIT
        checks++;
        if (ch_start !== 2'b00 || ch_op1 !== 32'h4000_0000) begin
            failures++;
            $display("FAIL %s_wait: got start=%b op1=%h required 00/40000000", name, ch_start, ch_op1);
        end
        ch_done = 2'b01; ch_res = {32'hAAAA_AAAA, 32'h4080_0000};
        step();                                   // cycle 3 captured
        ch_done = 2'b01; ch_res = {32'hBBBB_BBBB, 32'hDEAD_BEEF};
        step();                                   // repeat on ch0 ignored
        ch_done = 2'b10; ch_res = {r1, 32'hCCCC_CCCC};
        step();                                   // cycle 5 captured -> DRAIN
        ch_done = 2'b00; ch_res = '0;
        checks++;
        if (res_rdy !== 2'b01 || res !== 32'h4080_0000 || mismatch !== exp_mis) begin
            failures++;
            $display("FAIL %s_first: got rdy=%b res=%h mis=%b required 01/40800000/%b",
                     name, res_rdy, res, mismatch, exp_mis);
        end
        res_ack = 1'b1;
        step();
        checks++;
        if (res_rdy !== 2'b10 || res !== r1) begin
            failures++;
            $display("FAIL %s_second: got rdy=%b res=%h required 10/%h", name, res_rdy, res, r1);
        end
        step();
        checks++;
        if (res_rdy !== 2'b00 || res !== 32'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_empty: got rdy=%b res=%h busy=%b required 00/0/1", name, res_rdy, res, busy);
        end
        res_ack = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || mismatch !== exp_mis || timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: got busy=%b mis=%b tmo=%b required 0/%b/0", name, busy, mismatch, timeout, exp_mis);
        end
    endtask

    task automatic test_partial_mask();
        op1 = 32'h3F80_0000; op2 = 32'h4040_0000; in_rdy = 2'b10;
        step();
        in_rdy = 2'b00;
        checks++;
        if (ch_start !== 2'b10 || mismatch !== 1'b0) begin
            failures++;
            $display("FAIL partial_issue: got start=%b mis=%b required 10/0", ch_start, mismatch);
        end
        step();
        ch_done = 2'b01; ch_res = {32'h0, 32'h1234_5678};
        step();
        ch_done = 2'b00;
        checks++;
        if (res_rdy !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL partial_ignore: got rdy=%b busy=%b required 00/1", res_rdy, busy);
        end
        ch_done = 2'b10; ch_res = {32'h4040_0000, 32'h0};
        step();
        ch_done = 2'b00; ch_res = '0;
        checks++;
        if (res_rdy !== 2'b10 || res !== 32'h4040_0000) begin
            failures++;
            $display("FAIL partial_present: got rdy=%b res=%h required 10/40400000", res_rdy, res);
        end
        res_ack = 1'b1;
        step();
        checks++;
        if (res_rdy !== 2'b00) begin
            failures++;
            $display("FAIL partial_only_one: got rdy=%b required 00", res_rdy);
        end
        res_ack = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL partial_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_timeout();
        op1 = 32'h4000_0000; op2 = 32'h4000_0000; in_rdy = 2'b11;
        step();                                   // ISSUE
        in_rdy = 2'b00;
        step();                                   // WAIT, timer 0
        ch_done = 2'b01; ch_res = {32'h0, 32'h1234_5678};
        step();                                   // WAIT edge 1
        ch_done = 2'b00; ch_res = '0;
        for (int k = 0; k < 62; k++) step();      // WAIT edge 63
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0 || res_rdy !== 2'b00) begin
            failures++;
            $display("FAIL timeout_early: got busy=%b tmo=%b rdy=%b required 1/0/00", busy, timeout, res_rdy);
        end
        step();                                   // WAIT edge 64 -> DRAIN
        checks++;
        if (timeout !== 1'b1 || res_rdy !== 2'b01 || res !== 32'h1234_5678) begin
            failures++;
            $display("FAIL timeout_drain: got tmo=%b rdy=%b res=%h required 1/01/12345678", timeout, res_rdy, res);
        end
        res_ack = 1'b1;
        step();
        checks++;
        if (res_rdy !== 2'b00) begin
            failures++;
            $display("FAIL timeout_only_one: got rdy=%b required 00", res_rdy);
        end
        res_ack = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_hold: got busy=%b tmo=%b required 0/1", busy, timeout);
        end
    endtask

    task automatic test_timeout_empty();
        in_rdy = 2'b01;
        step();
        in_rdy = 2'b00;
        for (int k = 0; k < 65; k++) step();
        checks++;
        if (timeout !== 1'b1 || res_rdy !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_empty_drain: got tmo=%b rdy=%b busy=%b required 1/00/1", timeout, res_rdy, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_empty_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_pressure();
        in_rdy = 2'b11;
        step();
        in_rdy = 2'b00;
        step();
        ch_done = 2'b11; ch_res = {32'h4100_0000, 32'h40C0_0000};
        step();
        ch_done = 2'b00; ch_res = '0;
        checks++;
        if (mismatch !== 1'b1) begin
            failures++;
            $display("FAIL bp_mismatch: got mis=%b required 1", mismatch);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (res_rdy !== 2'b01 || res !== 32'h40C0_0000) begin
                failures++;
                $display("FAIL bp_stall%0d: got rdy=%b res=%h required 01/40c00000", k, res_rdy, res);
            end
            step();
        end
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        checks++;
        if (res_rdy !== 2'b10 || res !== 32'h4100_0000) begin
            failures++;
            $display("FAIL bp_next: got rdy=%b res=%h required 10/41000000", res_rdy, res);
        end
        res_ack = 1'b1;
        step();
        step();                                   // ack with nothing presented
        res_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_rdy !== 2'b00) begin
            failures++;
            $display("FAIL bp_idle: got busy=%b rdy=%b required 0/00", busy, res_rdy);
        end
    endtask

    task automatic test_reset_mid();
        op1 = 32'h4000_0000; op2 = 32'h4000_0000; in_rdy = 2'b11;
        step();
        in_rdy = 2'b00;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({ch_op1, ch_op2, ch_start, res, res_rdy, busy, mismatch, timeout} !== 103'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got op1=%h start=%b rdy=%b busy=%b required all zero",
                     ch_op1, ch_start, res_rdy, busy);
        end
        ch_done = 2'b11; ch_res = {32'h4080_0000, 32'h4080_0000};
        step();
        ch_done = 2'b00; ch_res = '0;
        checks++;
        if (busy !== 1'b0 || res_rdy !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_late_done: got busy=%b rdy=%b required 0/00", busy, res_rdy);
        end
        op1 = 32'h3F80_0000; op2 = 32'h3F00_0000; in_rdy = 2'b01;
        step();
        in_rdy = 2'b00;
        checks++;
        if (ch_start !== 2'b01 || ch_op1 !== 32'h3F80_0000 || ch_op2 !== 32'h3F00_0000) begin
            failures++;
            $display("FAIL rstmid_restart: got start=%b op1=%h op2=%h required 01/3f800000/3f000000",
                     ch_start, ch_op1, ch_op2);
        end
        step();
        ch_done = 2'b01; ch_res = {32'h0, 32'h3F00_0000};
        step();
        ch_done = 2'b00; ch_res = '0;
        checks++;
        if (res_rdy !== 2'b01 || res !== 32'h3F00_0000 || mismatch !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_result: got rdy=%b res=%h mis=%b required 01/3f000000/0", res_rdy, res, mismatch);
        end
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle: got busy=%b required 0", busy);
        end
    endtask

    initial begin
        rst = 1'b1; op1 = '0; op2 = '0; in_rdy = '0; ch_done = '0; ch_res = '0; res_ack = 1'b0;
        test_reset();
        test_dual("match", 32'h4080_0000, 1'b0);
        test_dual("mismatch", 32'h4080_0001, 1'b1);
        test_partial_mask();
        test_timeout();
        test_timeout_empty();
        test_back_pressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
